wb_trace_fifo: RTL and testbench
================================

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, entry count (power of two, 4..64).
REQ-002 SHALL provide parameter AW, default 4, pointer width, equal to log2(DEPTH).
REQ-003 SHALL provide port Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port PC_in  input  32  PC value paired with the write-back event.
REQ-006 SHALL provide port WB_WriteData  input  32  write-back data from the pipeline's WB stage.
REQ-007 SHALL provide port WB_Valid  input  1  qualifies a write-back event this cycle.
REQ-008 SHALL provide port Freeze  input  1  when high, capture is suppressed; the read side still operates.
REQ-009 SHALL provide port Flush  input  1  synchronous clear of all entries.
REQ-010 SHALL provide port out_valid  output  1  head entry is available.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts the head entry.
REQ-012 SHALL provide port out_pc  output  32  PC field of the head entry.
REQ-013 SHALL provide port out_data  output  32  data field of the head entry.
REQ-014 SHALL provide port count  output  AW+1  number of stored entries.
REQ-015 SHALL provide ports full and empty, each output 1, reporting occupancy status.
REQ-016 SHALL provide port overflow  output  1  sticky flag: at least one event was dropped.

Function
REQ-017 Push SHALL occur when WB_Valid=1, Freeze=0, Flush=0, and either full=0 or a pop occurs in the same cycle.
REQ-018 Pop SHALL occur when out_valid=1, out_ready=1 and Flush=0.
REQ-019 Storage SHALL be first-word-fall-through: out_pc and out_data SHALL show the head entry combinationally from storage, with no extra read latency.
REQ-020 Push-to-out_valid latency SHALL be 1 cycle when the FIFO is empty; there is no bypass.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; this applies at full, at empty (pop is impossible at empty, so push only) and at intermediate levels.
REQ-022 Read and write pointers SHALL be AW bits wide and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-023 The output and status relations SHALL be: out_valid = ~empty; full = (count==DEPTH); empty = (count==0).
REQ-024 A push attempt while full with no same-cycle pop SHALL drop the event and set overflow=1; stored contents SHALL be unchanged.
REQ-025 overflow SHALL be cleared only by Reset or Flush.
REQ-026 Flush SHALL zero both pointers, count and overflow on the next edge, and SHALL override any push or pop in the same cycle.
REQ-027 When out_valid=0, out_pc and out_data SHALL be don't-care, and the bench SHALL NOT check them.
REQ-028 A WB_Valid pulse while Freeze=1 SHALL be ignored and SHALL NOT set overflow.

Reset
REQ-029 Reset=1 SHALL asynchronously force both pointers and count to 0, overflow=0, out_valid=0, empty=1 and full=0.
REQ-030 Storage array contents SHALL NOT require reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries, and the first push after deassertion SHALL appear as the head entry.

Configuration
REQ-032 With macro WB_TRACE_DROP_CNT_EN defined, the block SHALL add port drop_cnt  output  16, counting dropped events.
REQ-033 With WB_TRACE_DROP_CNT_EN defined, drop_cnt SHALL saturate at 16'hFFFF and SHALL be cleared by Reset or Flush.
REQ-034 Without WB_TRACE_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent, and only the overflow flag SHALL be provided.

Verification
REQ-035 Reset, then push (PC 0x0, data 0x5), (PC 0x4, data 0xA) with out_ready=0 -> count=2; head 0x0/0x5; one cycle later with out_ready=1 -> head 0x4/0xA.
REQ-036 Fill 16 entries with out_ready=0, then push a 17th (data 0xDEAD) -> full=1, overflow=1, entry 0xDEAD absent on drain, drop_cnt=1 when enabled.
REQ-037 At full, push and pop in the same cycle -> count stays 16, popped entry is entry 0, new entry read last; repeat 40 cycles to exercise pointer wrap.
REQ-038 Freeze=1 with 3 WB_Valid pulses -> count=0, overflow=0; Flush at count=9 with a concurrent push -> count=0, empty=1 next cycle.
REQ-039 Assert Reset asynchronously between edges at count=5 -> out_valid=0 immediately; push data 0x77 after release -> head=0x77.
REQ-040 With WB_TRACE_DROP_CNT_EN defined, force 70000 drops -> drop_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: first-word-fall-through FIFO capturing (PC, write-back data) trace pairs.
// Define WB_TRACE_DROP_CNT_EN to add a 16-bit saturating drop counter output (drop_cnt).
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [31:0]   PC_in,
  input  logic [31:0]   WB_WriteData,
  input  logic          WB_Valid,
  input  logic          Freeze,
  input  logic          Flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
`ifdef WB_TRACE_DROP_CNT_EN
  output logic          overflow,
  output logic [15:0]   drop_cnt
`else
  output logic          overflow
`endif
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic          attempt;
  logic          push;
  logic          pop;
  logic          drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign attempt = WB_Valid & ~Freeze & ~Flush;
  assign pop     = out_valid & out_ready & ~Flush;
  assign push    = attempt & (~full | pop);
  assign drop    = attempt & full & ~pop;

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_COUNT);
  assign out_valid = ~empty;
  assign {out_pc, out_data} = mem[rd_ptr];

  always_ff @(posedge Clk) begin
    if (push) begin
      mem[wr_ptr] <= {PC_in, WB_WriteData};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else if (Flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef WB_TRACE_DROP_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      drop_cnt <= '0;
    end else if (Flush) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo: directed bench for wb_trace_fifo with a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        Clk;
  logic        Reset;
  logic [31:0] PC_in;
  logic [31:0] WB_WriteData;
  logic        WB_Valid;
  logic        Freeze;
  logic        Flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_data;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic        overflow;
`ifdef WB_TRACE_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] model_q[$];
  logic        model_overflow;
  logic [15:0] model_drops;

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .PC_in(PC_in),
    .WB_WriteData(WB_WriteData),
    .WB_Valid(WB_Valid),
    .Freeze(Freeze),
    .Flush(Flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_data(out_data),
    .count(count),
    .full(full),
    .empty(empty),
`ifdef WB_TRACE_DROP_CNT_EN
    .overflow(overflow),
    .drop_cnt(drop_cnt)
`else
    .overflow(overflow)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, data} updated from the push/pop rules.
  always @(posedge Clk or posedge Reset) begin
    if (Reset || Flush) begin
      model_q.delete();
      model_overflow = 1'b0;
      model_drops    = 16'h0;
    end else begin
      automatic bit do_pop  = (model_q.size() != 0) && out_ready;
      automatic bit attempt = WB_Valid && !Freeze;
      if (attempt && model_q.size() == DEPTH && !do_pop) begin
        model_overflow = 1'b1;
        if (model_drops != 16'hFFFF) model_drops = model_drops + 16'h1;
      end
      if (do_pop) void'(model_q.pop_front());
      if (attempt && model_q.size() < DEPTH) model_q.push_back({PC_in, WB_WriteData});
    end
  end

  always @(negedge Clk) begin
    check_output("count", 64'(count), 64'(model_q.size()));
    check_output("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
    check_output("empty", 64'(empty), 64'(model_q.size() == 0));
    check_output("full", 64'(full), 64'(model_q.size() == DEPTH));
    check_output("overflow", 64'(overflow), 64'(model_overflow));
`ifdef WB_TRACE_DROP_CNT_EN
    check_output("drop_cnt", 64'(drop_cnt), 64'(model_drops));
`endif
    if (model_q.size() != 0) check_output("head", {out_pc, out_data}, model_q[0]);
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic [31:0] data,
                                input logic rdy, input logic frz, input logic fl);
    WB_Valid     = v;
    PC_in        = pc;
    WB_WriteData = data;
    out_ready    = rdy;
    Freeze       = frz;
    Flush        = fl;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b1, 32'(i * 4), base + 32'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
  endtask

  initial begin
    Reset = 1'b1;
    idle();
    #12;
    check_output("rst_count", 64'(count), 64'd0);
    check_output("rst_empty", 64'(empty), 64'd1);
    check_output("rst_full", 64'(full), 64'd0);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    #1 Reset = 1'b0;

    // Two pushes, then a single pop reveals the second entry.
    apply_stimulus(1'b1, 32'h0, 32'h5, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h4, 32'hA, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check_output("two_count", 64'(count), 64'd2);
    check_output("two_head", {out_pc, out_data}, {32'h0, 32'h5});
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("pop_head", {out_pc, out_data}, {32'h4, 32'hA});
    check_output("pop_count", 64'(count), 64'd1);
    tick();
    check_output("drained_empty", 64'(empty), 64'd1);
    idle();

    // Overflow: the 17th event is dropped and never drains.
    fill(16, 32'h100);
    check_output("fill_full", 64'(full), 64'd1);
    check_output("fill_count", 64'(count), 64'd16);
    apply_stimulus(1'b1, 32'h40, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("ovf_flag", 64'(overflow), 64'd1);
    check_output("ovf_count", 64'(count), 64'd16);
`ifdef WB_TRACE_DROP_CNT_EN
    check_output("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check_output("ovf_drain", 64'(out_data), 64'(32'h100 + i));
      tick();
    end
    check_output("ovf_drained_empty", 64'(empty), 64'd1);
    check_output("ovf_sticky", 64'(overflow), 64'd1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("flush_clears_ovf", 64'(overflow), 64'd0);
    idle();

    // Push and pop together at full for 40 cycles to wrap both pointers.
    fill(16, 32'h200);
    for (int k = 0; k < 40; k++) begin
      apply_stimulus(1'b1, 32'h1000 + 32'(k * 4), 32'h300 + 32'(k), 1'b1, 1'b0, 1'b0);
      check_output("wrap_head", 64'(out_data), (k < 16) ? 64'(32'h200 + k) : 64'(32'h300 + k - 16));
      tick();
      check_output("wrap_count", 64'(count), 64'd16);
    end
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      check_output("wrap_drain", 64'(out_data), 64'(32'h300 + 24 + j));
      tick();
    end
    check_output("wrap_empty", 64'(empty), 64'd1);
    idle();

    // Frozen capture ignores events; flush beats a concurrent push.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 32'h50, 32'h55, 1'b0, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check_output("freeze_count", 64'(count), 64'd0);
    check_output("freeze_overflow", 64'(overflow), 64'd0);
    fill(9, 32'h400);
    check_output("pre_flush_count", 64'(count), 64'd9);
    apply_stimulus(1'b1, 32'h60, 32'h66, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    check_output("flush_count", 64'(count), 64'd0);
    check_output("flush_empty", 64'(empty), 64'd1);

    // Asynchronous reset between edges discards stored entries.
    fill(5, 32'h500);
    check_output("pre_rst_count", 64'(count), 64'd5);
    #4 Reset = 1'b1;
    #1;
    check_output("async_out_valid", 64'(out_valid), 64'd0);
    check_output("async_count", 64'(count), 64'd0);
    #1 Reset = 1'b0;
    apply_stimulus(1'b1, 32'h70, 32'h77, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    check_output("post_rst_head", {out_pc, out_data}, {32'h70, 32'h77});
    check_output("post_rst_count", 64'(count), 64'd1);
    apply_stimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    tick();
    idle();

`ifdef WB_TRACE_DROP_CNT_EN
    // Drop counter saturates and holds.
    fill(16, 32'h600);
    apply_stimulus(1'b1, 32'h80, 32'h88, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) tick();
    check_output("drop_sat", 64'(drop_cnt), 64'hFFFF);
    for (int i = 0; i < 5; i++) tick();
    check_output("drop_hold", 64'(drop_cnt), 64'hFFFF);
    idle();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
